uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares one UART byte transmitter among `NREQ` requesters. It generates the transmitter's bit-rate enable, accepts one byte per frame over a valid/ready handshake, and presents it with a load strobe. It then holds off further loads until the transmitter has returned to idle. It sits between the command/data producers and the UART transmit datapath.

## Interface
- `NREQ`, 4: number of requesters; at least 2.
- `CLK_DIV`, 16: clk cycles per bit-enable tick; at least 2.
- `FRAME_TICKS`, 12: minimum number of ticks between successive load-sampling ticks; at least 12.
- `clk` in 1: single clock, rising edge.
- `rst_` in 1: asynchronous, active-low reset.
- `sched_en` in 1: when high, new grants are allowed; an in-flight frame always completes.
- `req_valid` in NREQ: per-requester byte available.
- `req_data` in 8*NREQ: byte of requester i is at bits [8i+7:8i].
- `req_ready` out NREQ: one-hot accept signal; a transfer happens on a cycle where `req_valid[i]` and `req_ready[i]` are both high.
- `tx_en` out 1: bit-rate tick to the transmitter; one clk cycle wide.
- `tx_bt` out 1: load strobe to the transmitter.
- `tx_din` out 8: byte presented to the transmitter.
- `busy` out 1: high whenever the state is not IDLE.
- `grant_id` out clog2(NREQ): index of the last granted requester.

## Operation
- **Tick divider.** The counter `div` counts from 0 to CLK_DIV-1 and wraps. `tx_en` is a register that is 1 in the cycle after `div` equals CLK_DIV-1. The divider free-runs and is independent of the FSM state.
- **FSM state IDLE.** When `sched_en` is high and any `req_valid` bit is set:
  - Choose the first set bit searching from `last+1` upward, wrapping modulo NREQ.
  - `req_ready[winner]` is driven combinationally high in this cycle.
  - On the clock edge: `tx_din` takes the winner's data, `last` and `grant_id` take the winner index, `tx_bt` becomes 1, and the state moves to LOAD.
  - In all other cases `req_ready` is all zeros.
- **FSM state LOAD.** Hold `tx_bt` at 1 and `tx_din` stable. The first cycle with `tx_en` high is the sampling tick (tick k). On that edge, `tx_bt` becomes 0, `fcnt` takes FRAME_TICKS-1, and the state moves to WAIT.
- **FSM state WAIT.** On each `tx_en` tick:
  - If `fcnt` equals 1, the state moves to IDLE.
  - Otherwise `fcnt` decrements.
  - The move to IDLE therefore happens at tick k+FRAME_TICKS-1.
  - The earliest next sampling tick is k+FRAME_TICKS.
  - `tx_din` stays stable throughout WAIT.
- **Reset values.** On reset, `last` takes NREQ-1, so requester 0 has first priority.
- **Boundary conditions:**
  - **`sched_en` drops in LOAD or WAIT:** the frame still completes, and no grant is made afterwards.
  - **`req_valid` drops while in LOAD or WAIT:** ignored, because the data is already captured.
  - **Only one requester valid:** it is granted repeatedly, one grant per frame.
  - **Entry to LOAD with `tx_en` high in the same cycle:** not possible, because `tx_en` is sampled only while already in LOAD. The sampling tick is always a tick that occurs while `tx_bt` is high.
- **Asynchronous reset assertion at any time, including mid-frame:** immediately forces the following values:
  - `div` = 0
  - `tx_en` = 0
  - `tx_bt` = 0
  - `tx_din` = 0
  - `fcnt` = 0
  - `grant_id` = 0
  - `busy` = 0
  - `req_ready` = 0
  - state = IDLE
  - The in-flight frame is abandoned.

## Timing
- **Grant latency:** `req_ready` goes high in the same cycle as `req_valid` when the state is IDLE and `sched_en` is high.
- **Strobe duration:** `tx_bt` goes high one cycle after the grant and stays high until just after the next tick, which is between 1 and CLK_DIV cycles.
- **Frame-to-frame spacing:** with continuous requests, sampling ticks are exactly FRAME_TICKS ticks apart, i.e. FRAME_TICKS×CLK_DIV clk cycles.
- **`busy` timing:** `busy` rises on the edge after the grant and falls on the edge of tick k+FRAME_TICKS-1.
- **Output registration:** all outputs except `req_ready` are registered.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state encoding: IDLE, LOAD, WAIT.
  - Default values of FRAME_TICKS and CLK_DIV.
  - The byte-width constant 8.
- **Sub-module `uart_baud_tick`:** contains the divider. Parameter CLK_DIV; ports `clk`, `rst_`, `tick`. It is reused by the receive side.
- **Top-level logic:** the round-robin priority search and the FSM stay in the top module.

## Test plan
All scenarios use NREQ=4, CLK_DIV=4, FRAME_TICKS=12.
1. **Reset:** hold `rst_` low → all outputs 0; after release, `tx_en` pulses every 4 cycles, starting with `div` at 0.
2. **Single request:** requester 2 valid with data 0xA5 → `req_ready` = 4'b0100 for one cycle; `tx_din` = 0xA5; `tx_bt` high until the next tick; `busy` high for 11 ticks after the sampling tick; `grant_id` = 2.
3. **Continuous round-robin:** all four requesters valid continuously, data 0x10/0x11/0x12/0x13 → grant order 0,1,2,3,0; sampling ticks 48 clk apart; each `tx_din` matches the granted requester's data.
4. **Single requester that is also the last granted:** with `last` = 1, only requester 1 valid → it is granted; then requester 3 asserts valid while in WAIT → requester 3 is granted next in IDLE.
5. **`sched_en` dropped mid-frame:** `sched_en` goes low in WAIT while requests are pending → the current frame completes, `busy` falls, and `req_ready` stays 0 until `sched_en` returns high.
6. **Reset mid-frame:** `rst_` asserted during WAIT at `fcnt` = 5 → all outputs immediately take their reset values; after release, the pending requester 0 is granted first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler and its bit-rate divider.
package uart_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned CLK_DIV_DEF     = 16;
    localparam int unsigned FRAME_TICKS_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-rate divider: one-cycle tick in the cycle after the count wraps.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_,
    output logic tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_q;
    logic             wrap;

    assign wrap  = (div_q == DIV_W'(CLK_DIV - 1));
    assign div_d = wrap ? '0 : div_q + DIV_W'(1);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= wrap;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter among NREQ requesters.
// Grants one byte per frame and blocks further loads until the frame has elapsed.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
    parameter int unsigned FRAME_TICKS = FRAME_TICKS_DEF
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       sched_en,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [BYTE_W*NREQ-1:0]     req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       tx_en,
    output logic                       tx_bt,
    output logic [BYTE_W-1:0]          tx_din,
    output logic                       busy,
    output logic [$clog2(NREQ)-1:0]    grant_id
);

    localparam int unsigned ID_W   = $clog2(NREQ);
    localparam int unsigned FCNT_W = $clog2(FRAME_TICKS);

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic              tx_bt_q, tx_bt_d;
    logic [BYTE_W-1:0] tx_din_q, tx_din_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              busy_q, busy_d;

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   cand;
    logic              grant_ok;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst_ (rst_),
        .tick (tx_en)
    );

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = ID_W'((32'(last_q) + i) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // rst_ gates the combinational accept so it is low while reset is held.
    assign grant_ok = (state_q == ST_IDLE) && sched_en && rst_ && win_found;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= ST_IDLE;
            last_q   <= ID_W'(NREQ - 1);
            grant_q  <= '0;
            tx_bt_q  <= 1'b0;
            tx_din_q <= '0;
            fcnt_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            tx_bt_q  <= tx_bt_d;
            tx_din_q <= tx_din_d;
            fcnt_q   <= fcnt_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_ok) state_d = ST_LOAD;
            ST_LOAD: if (tx_en) state_d = ST_WAIT;
            ST_WAIT: if (tx_en && (fcnt_q == FCNT_W'(1))) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        last_d    = last_q;
        grant_d   = grant_q;
        tx_bt_d   = tx_bt_q;
        tx_din_d  = tx_din_q;
        fcnt_d    = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    req_ready[win_idx] = 1'b1;
                    tx_din_d           = req_data[BYTE_W*win_idx +: BYTE_W];
                    last_d             = win_idx;
                    grant_d            = win_idx;
                    tx_bt_d            = 1'b1;
                end
            end
            ST_LOAD: begin
                if (tx_en) begin
                    tx_bt_d = 1'b0;
                    fcnt_d  = FCNT_W'(FRAME_TICKS - 1);
                end
            end
            ST_WAIT: begin
                if (tx_en && (fcnt_q != FCNT_W'(1))) fcnt_d = fcnt_q - FCNT_W'(1);
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign tx_bt    = tx_bt_q;
    assign tx_din   = tx_din_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with NREQ=4, CLK_DIV=4, FRAME_TICKS=12.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_;
    logic        sched_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_en;
    logic        tx_bt;
    logic [7:0]  tx_din;
    logic        busy;
    logic [1:0]  grant_id;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0] valid;
        logic       en;
        logic [3:0] ready;
        logic       ten;
        logic       bt;
        logic       bsy;
        logic [1:0] gid;
        logic [7:0] din;
    } vec_t;

    vec_t tbl[13];

    uart_tx_sched #(
        .NREQ        (4),
        .CLK_DIV     (4),
        .FRAME_TICKS (12)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .sched_en  (sched_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_en     (tx_en),
        .tx_bt     (tx_bt),
        .tx_din    (tx_din),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        #1;
        check("rst_tx_en",  32'(tx_en),     32'd0);
        check("rst_tx_bt",  32'(tx_bt),     32'd0);
        check("rst_tx_din", 32'(tx_din),    32'd0);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_gid",    32'(grant_id),  32'd0);
        check("rst_ready",  32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
        cyc  = 0;
    endtask

    initial begin
        int         gcnt;
        int         scnt;
        int         bad;
        int         exp_gcyc[5];
        logic [3:0] exp_rr[5];
        int         exp_scyc[5];
        logic [7:0] exp_sdin[5];

        // cycle-by-cycle rows for reset release and a single grant to requester 2
        tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[1]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[7]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 8'hA5};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 8'hA5};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 8'hA5};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, 8'hA5};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 8'hA5};

        exp_gcyc = '{2, 49, 97, 145, 193};
        exp_rr   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_scyc = '{4, 52, 100, 148, 196};
        exp_sdin = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

        // Reset with requests pending: accept must stay low
        rst_      = 1'b1;
        sched_en  = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'h44A5_2211;
        #2;
        rst_ = 1'b0;
        #1;
        check("rst_ready_gated", 32'(req_ready), 32'd0);
        req_valid = 4'b0000;
        sched_en  = 1'b0;
        do_reset();
        check("c0_tx_en", 32'(tx_en), 32'd0);

        // Table: divider phase after release, then single grant of requester 2
        for (int i = 0; i < 13; i++) begin
            step();
            req_valid = tbl[i].valid;
            sched_en  = tbl[i].en;
            #1;
            check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
            check($sformatf("tbl%0d_tx_en", i), 32'(tx_en),     32'(tbl[i].ten));
            check($sformatf("tbl%0d_tx_bt", i), 32'(tx_bt),     32'(tbl[i].bt));
            check($sformatf("tbl%0d_busy", i),  32'(busy),      32'(tbl[i].bsy));
            check($sformatf("tbl%0d_gid", i),   32'(grant_id),  32'(tbl[i].gid));
            check($sformatf("tbl%0d_din", i),   32'(tx_din),    32'(tbl[i].din));
        end
        run_to(56);
        check("s2_busy_last", 32'(busy),   32'd1);
        check("s2_din_hold",  32'(tx_din), 32'hA5);
        run_to(57);
        check("s2_busy_fall", 32'(busy),   32'd0);
        check("s2_bt_low",    32'(tx_bt),  32'd0);

        // Continuous round-robin across all four requesters
        req_valid = 4'b0000;
        do_reset();
        run_to(2);
        req_data  = 32'h1312_1110;
        req_valid = 4'b1111;
        sched_en  = 1'b1;
        #1;
        gcnt = 0;
        scnt = 0;
        for (int k = 0; k < 196; k++) begin
            if (req_ready != 4'b0000) begin
                if (gcnt < 5) begin
                    check($sformatf("rr%0d_ready", gcnt), 32'(req_ready), 32'(exp_rr[gcnt]));
                    check($sformatf("rr%0d_cycle", gcnt), 32'(cyc),       32'(exp_gcyc[gcnt]));
                end
                gcnt++;
            end
            if (tx_en && tx_bt) begin
                if (scnt < 5) begin
                    check($sformatf("smp%0d_cycle", scnt), 32'(cyc),    32'(exp_scyc[scnt]));
                    check($sformatf("smp%0d_din", scnt),   32'(tx_din), 32'(exp_sdin[scnt]));
                end
                scnt++;
            end
            step();
        end
        check("rr_grant_count",  32'(gcnt), 32'd5);
        check("rr_sample_count", 32'(scnt), 32'd5);

        // Lone requester that is also last granted, then requester 3 joins
        req_valid = 4'b0000;
        do_reset();
        run_to(2);
        req_data  = 32'hC300_5A00;
        req_valid = 4'b0010;
        sched_en  = 1'b1;
        #1;
        check("s4_ready_a", 32'(req_ready), 32'b0010);
        run_to(3);
        check("s4_gid_a", 32'(grant_id), 32'd1);
        check("s4_din_a", 32'(tx_din),   32'h5A);
        check("s4_bt_a",  32'(tx_bt),    32'd1);
        run_to(49);
        check("s4_busy_idle", 32'(busy),      32'd0);
        check("s4_ready_b",   32'(req_ready), 32'b0010);
        run_to(50);
        check("s4_gid_b", 32'(grant_id), 32'd1);
        run_to(60);
        req_valid = 4'b1010;
        #1;
        check("s4_wait_no_ready", 32'(req_ready), 32'd0);
        run_to(97);
        check("s4_ready_c", 32'(req_ready), 32'b1000);
        run_to(98);
        check("s4_gid_c", 32'(grant_id), 32'd3);
        check("s4_din_c", 32'(tx_din),   32'hC3);

        // sched_en dropped during WAIT: frame completes, no new grant
        run_to(110);
        sched_en = 1'b0;
        run_to(144);
        check("s5_busy_hold", 32'(busy), 32'd1);
        run_to(145);
        check("s5_busy_fall", 32'(busy),   32'd0);
        check("s5_din_hold",  32'(tx_din), 32'hC3);
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            if (req_ready != 4'b0000) bad++;
            step();
        end
        check("s5_ready_blocked", 32'(bad), 32'd0);
        sched_en = 1'b1;
        #1;
        check("s5_ready_resume", 32'(req_ready), 32'b0010);
        run_to(161);
        check("s5_gid", 32'(grant_id), 32'd1);
        check("s5_bt",  32'(tx_bt),    32'd1);

        // Async reset in WAIT at fcnt=5, requester 0 pending
        run_to(189);
        req_data  = 32'hC300_5A77;
        req_valid = 4'b0001;
        #1;
        check("s6_busy_pre", 32'(busy),  32'd1);
        check("s6_bt_pre",   32'(tx_bt), 32'd0);
        #2;
        do_reset();
        #1;
        check("s6_ready_after", 32'(req_ready), 32'b0001);
        run_to(1);
        check("s6_gid",  32'(grant_id), 32'd0);
        check("s6_din",  32'(tx_din),   32'h77);
        check("s6_bt",   32'(tx_bt),    32'd1);
        check("s6_busy", 32'(busy),     32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
